// File: rtl/yarp_pkg.sv
// yarp_pkg: opcode/funct7 constants and the decoded-bundle type shared by the decode stage
package yarp_pkg;
  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] I_TYPE_0  = 7'b0000011;
  localparam logic [6:0] I_TYPE_1  = 7'b0010011;
  localparam logic [6:0] I_TYPE_2  = 7'b1100111;
  localparam logic [6:0] S_TYPE    = 7'b0100011;
  localparam logic [6:0] B_TYPE    = 7'b1100011;
  localparam logic [6:0] U_TYPE_0  = 7'b0110111;
  localparam logic [6:0] U_TYPE_1  = 7'b0010111;
  localparam logic [6:0] J_TYPE    = 7'b1101111;
  localparam logic [6:0] FENCE_OP  = 7'b0001111;
  localparam logic [6:0] SYSTEM_OP = 7'b1110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        r_type;
    logic        i_type;
    logic        s_type;
    logic        b_type;
    logic        u_type;
    logic        j_type;
    logic        sys;
    logic        illegal;
    logic [31:0] imm;
  } decode_t;
endpackage

// File: rtl/yarp_decode_core.sv
// yarp_decode_core: combinational instruction word -> decoded bundle (fields, type flags, immediate, illegal)
module yarp_decode_core
  import yarp_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int M_EXT    = 0,
  parameter int SYS_EN   = 1
) (
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output decode_t     dec_o
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic r, i, s, b, u, j, sys, bad, use_rs1, use_rs2, use_rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
  assign imm_b = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'h0};
  assign imm_j = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  always_comb begin
    {r, i, s, b, u, j, sys, bad} = '0;
    {use_rs1, use_rs2, use_rd} = '0;
    case (op)
      R_TYPE: begin
        r = 1'b1;
        {use_rs1, use_rs2, use_rd} = 3'b111;
        bad = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) ||
                (f7 == F7_MULDIV && M_EXT != 0));
      end
      I_TYPE_0: begin
        i = 1'b1;
        {use_rs1, use_rd} = 2'b11;
        bad = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
      end
      I_TYPE_1: begin
        i = 1'b1;
        {use_rs1, use_rd} = 2'b11;
        bad = (f3 == 3'b001 && f7 != F7_BASE) || (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT);
      end
      I_TYPE_2: begin
        i = 1'b1;
        {use_rs1, use_rd} = 2'b11;
        bad = f3 != 3'b000;
      end
      S_TYPE: begin
        s = 1'b1;
        {use_rs1, use_rs2} = 2'b11;
        bad = f3 > 3'b010;
      end
      B_TYPE: begin
        b = 1'b1;
        {use_rs1, use_rs2} = 2'b11;
        bad = f3 == 3'b010 || f3 == 3'b011;
      end
      U_TYPE_0, U_TYPE_1: begin
        u = 1'b1;
        use_rd = 1'b1;
      end
      J_TYPE: begin
        j = 1'b1;
        use_rd = 1'b1;
      end
      FENCE_OP, SYSTEM_OP: begin
        i = 1'b1;
        sys = 1'b1;
        {use_rs1, use_rd} = 2'b11;
        bad = SYS_EN == 0;
      end
      default: bad = 1'b1;
    endcase
    // RV32E only has x0..x15, so any referenced register with bit 4 set is out of range
    if (NUM_REGS == 16)
      bad = bad || (use_rs1 && instr_i[19]) || (use_rs2 && instr_i[24]) || (use_rd && instr_i[11]);
  end
  always_comb begin
    dec_o = '0;
    dec_o.pc = pc_i;
    dec_o.rs1 = instr_i[19:15];
    dec_o.rs2 = instr_i[24:20];
    dec_o.rd = instr_i[11:7];
    dec_o.op = op;
    dec_o.funct3 = f3;
    dec_o.funct7 = f7;
    dec_o.illegal = bad;
    {dec_o.r_type, dec_o.i_type, dec_o.s_type, dec_o.b_type, dec_o.u_type, dec_o.j_type, dec_o.sys} =
      bad ? 7'b0 : {r, i, s, b, u, j, sys};
    dec_o.imm = bad ? 32'h0 : i ? imm_i : s ? imm_s : b ? imm_b : u ? imm_u : j ? imm_j : 32'h0;
  end
endmodule

// File: rtl/yarp_decode_stage.sv
// yarp_decode_stage: registered decode stage with a main register and one-entry skid so in_ready_o is registered
module yarp_decode_stage
  import yarp_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int M_EXT    = 0,
  parameter int SYS_EN   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output decode_t     dec_o
);
  decode_t dec, main_q, skid_q;
  logic main_valid_q, skid_valid_q, in_fire, main_free;
  yarp_decode_core #(.NUM_REGS(NUM_REGS), .M_EXT(M_EXT), .SYS_EN(SYS_EN)) u_core (
    .instr_i(instr_i),
    .pc_i(pc_i),
    .dec_o(dec)
  );
  assign in_ready_o = !skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign dec_o = main_q;
  assign in_fire = in_valid_i && in_ready_o;
  assign main_free = !main_valid_q || out_ready_i;
  // skid is only ever filled while main is stalled, so when main frees the skid entry is the older one
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (main_free) begin
      main_valid_q <= skid_valid_q || in_fire;
      skid_valid_q <= 1'b0;
      if (skid_valid_q) main_q <= skid_q;
      else if (in_fire) main_q <= dec;
    end else if (in_fire) begin
      skid_q <= dec;
      skid_valid_q <= 1'b1;
    end
  end
endmodule
